strobe_enable_gen: RTL and testbench
====================================

# strobe_enable_gen

Programmable enable-strobe generator: the driving end of the `enable` input that the lab counters (`count_1` and its kin) consume. On command it emits single-cycle `enable` strobes every `period` clocks, either for a fixed burst of `burst_len` strobes or continuously until stopped. It counts the strobes it has issued and reports completion. It sits between the control and user-input logic and the counter datapath, replacing hand-driven enable waveforms.

## Interface
- `DIV_W`, 8, width of `period`.
- `CNT_W`, 8, width of `burst_len` and `pulses`.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request a run; sampled only in IDLE.
- `stop`  in  1  abort a run; sampled in IDLE and RUN.
- `period`  in  DIV_W  strobe spacing in clocks; 0 is treated as 1; latched on start.
- `burst_len`  in  CNT_W  number of strobes per run; 0 means continuous; latched on start.
- `enable`  out  1  registered strobe to the counter.
- `busy`  out  1  high while a run is active.
- `done`  out  1  one-cycle pulse when a finite burst completes.
- `pulses`  out  CNT_W  strobes issued since the last accepted start.

## Operation
- Reset value of every output: `enable`=0, `busy`=0, `done`=0, `pulses`=0. State is IDLE and the phase counter is 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - `start`=1 and `stop`=0: latch `period` as P (0 is replaced by 1) and `burst_len` as N. Clear `pulses`, set phase to 1, set `busy`=1, go to RUN.
  - `start` and `stop` both high: `stop` wins and the block stays IDLE.
- RUN, each edge:
  - `stop`=1: go to IDLE with `enable`=0 and `busy`=0. `done` is not asserted and `pulses` holds its value. `stop` overrides a strobe due on the same edge.
  - phase == P: set `enable`=1, phase=1, `pulses`=`pulses`+1 (wraps modulo 2^CNT_W).
    - If N≠0 and `pulses`+1 == N, go to DONE.
  - Otherwise: set `enable`=0 and phase=phase+1.
  - `start` is ignored in RUN.
  - Changes to `period` or `burst_len` during a run have no effect.
- DONE, for exactly one edge: set `enable`=0, `busy`=0, `done`=1, then go to IDLE. `start` and `stop` are ignored in DONE.
- In IDLE, `done` returns to 0 on the next edge. `pulses` holds its final value until the next accepted start.
- Phase counter width is DIV_W; it never exceeds P.

## Timing
- Latency is measured from the rising edge that samples `start`=1 (edge 0).
- `busy` is high from edge 0.
- The first `enable` rises at edge P. Subsequent strobes come every P edges, each high for exactly one cycle.
- P=1: `enable` stays high continuously while RUN lasts.
- Last strobe of a burst: `busy` stays high during it. `done`=1 and `busy`=0 follow on the next edge, so `done` rises at edge N·P+1.
- `pulses` updates on the same edge that raises the corresponding `enable`.
- `stop` sampled at edge k: `enable`=0 and `busy`=0 after edge k.
- Earliest restart: `start` sampled on the edge after `done` (i.e. in IDLE). Back-to-back runs therefore have a one-cycle gap minimum after DONE.
- Asserting `reset` mid-run forces all outputs to their reset values immediately, independent of `clk`. The block resumes in IDLE on the first edge after `reset` deasserts.

## Test plan
- Burst: `period`=3, `burst_len`=4, pulse `start` at edge 0.
  - `enable` high after edges 3, 6, 9 and 12.
  - `pulses` reads 1, 2, 3, 4.
  - `done` high after edge 13 only; `busy` high from edge 0 through edge 12.
- Continuous, P=1: `period`=1, `burst_len`=0, `start`.
  - `enable` held high and `pulses` increments every cycle.
  - After 256 strobes `pulses` wraps to 0.
  - `stop` drops `enable` and `busy` on the next edge, with no `done`.
- Period zero: `period`=0, `burst_len`=2 behaves exactly as `period`=1.
  - `enable` high after edges 1 and 2.
  - `done` after edge 3.
- Start/stop conflicts:
  - `start`+`stop` together in IDLE: no run.
  - `start` re-pulsed mid-run: ignored, strobe spacing unchanged.
  - `period` changed mid-run: ignored.
- Stop versus strobe: `period`=4, `burst_len`=0, `stop` sampled at edge 8, where a strobe is due.
  - No strobe at edge 8; `pulses`=1 retained.
- Reset mid-run: assert `reset` asynchronously between edges during a burst.
  - All outputs go to 0 immediately.
  - After release, a new `start` runs normally from `pulses`=0.

Source files
------------

// File: rtl/strobe_enable_gen.sv
// Programmable enable-strobe generator: emits one-cycle enable strobes every
// P clocks, either for a burst of N strobes or continuously until stopped.
module strobe_enable_gen #(
   parameter int DIV_W = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             start_i,
   input  logic             stop_i,
   input  logic [DIV_W-1:0] period_i,
   input  logic [CNT_W-1:0] burst_len_i,
   output logic             enable_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [CNT_W-1:0] pulses_o
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]       state_q,  state_d;
   logic [DIV_W-1:0] period_q, period_d;
   logic [CNT_W-1:0] burst_q,  burst_d;
   logic [DIV_W-1:0] phase_q,  phase_d;
   logic [CNT_W-1:0] pulses_q, pulses_d;
   logic             enable_q, enable_d;
   logic             busy_q,   busy_d;
   logic             done_q,   done_d;
   logic [CNT_W-1:0] pulses_inc;

   assign pulses_inc = pulses_q + CNT_W'(1);

   always_comb begin
      state_d  = state_q;
      period_d = period_q;
      burst_d  = burst_q;
      phase_d  = phase_q;
      pulses_d = pulses_q;
      enable_d = 1'b0;
      busy_d   = busy_q;
      done_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // stop has priority over a simultaneous start
            if (start_i && !stop_i) begin
               period_d = (period_i == '0) ? DIV_W'(1) : period_i;
               burst_d  = burst_len_i;
               pulses_d = '0;
               phase_d  = DIV_W'(1);
               busy_d   = 1'b1;
               state_d  = ST_RUN;
            end
         end
         ST_RUN: begin
            if (stop_i) begin
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end else if (phase_q == period_q) begin
               enable_d = 1'b1;
               phase_d  = DIV_W'(1);
               pulses_d = pulses_inc;
               if (burst_q != '0 && pulses_inc == burst_q) begin
                  state_d = ST_DONE;
               end
            end else begin
               phase_d = phase_q + DIV_W'(1);
            end
         end
         ST_DONE: begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q  <= ST_IDLE;
         period_q <= '0;
         burst_q  <= '0;
         phase_q  <= '0;
         pulses_q <= '0;
         enable_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         period_q <= period_d;
         burst_q  <= burst_d;
         phase_q  <= phase_d;
         pulses_q <= pulses_d;
         enable_q <= enable_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign enable_o = enable_q;
   assign busy_o   = busy_q;
   assign done_o   = done_q;
   assign pulses_o = pulses_q;

endmodule

// File: tb/tb_strobe_enable_gen.sv
// Directed bench for strobe_enable_gen: an edge-counting reference model checked
// every cycle, plus literal expectations at key edges of each scenario.
module tb_strobe_enable_gen;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic [7:0] period = 8'd0;
   logic [7:0] burst_len = 8'd0;
   logic       enable, busy, done;
   logic [7:0] pulses;

   int checks = 0;
   int errors = 0;

   strobe_enable_gen #(.DIV_W(8), .CNT_W(8)) dut (
      .clk_i      (clk),
      .reset_i    (rst),
      .start_i    (start),
      .stop_i     (stop),
      .period_i   (period),
      .burst_len_i(burst_len),
      .enable_o   (enable),
      .busy_o     (busy),
      .done_o     (done),
      .pulses_o   (pulses)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: counts edges since the accepted start; a strobe is due
   // whenever that count is a multiple of P.
   int mode = 0;        // 0 idle, 1 running, 2 finishing
   int k = 0;
   int mp = 1;
   int mn = 0;
   int issued = 0;
   int m_en = 0, m_busy = 0, m_done = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mode = 0; k = 0; issued = 0;
         m_en = 0; m_busy = 0; m_done = 0;
      end else begin
         m_en = 0;
         m_done = 0;
         if (mode == 2) begin
            m_busy = 0; m_done = 1; mode = 0;
         end else if (mode == 0) begin
            if (start && !stop) begin
               mp = (period == 0) ? 1 : int'(period);
               mn = int'(burst_len);
               k = 0; issued = 0; m_busy = 1; mode = 1;
            end
         end else begin
            k++;
            if (stop) begin
               m_busy = 0; mode = 0;
            end else if (k % mp == 0) begin
               m_en = 1;
               issued++;
               if (mn != 0 && issued == mn) mode = 2;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("model_enable", int'(enable), m_en);
         chk("model_busy",   int'(busy),   m_busy);
         chk("model_done",   int'(done),   m_done);
         chk("model_pulses", int'(pulses), issued % 256);
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   initial begin
      // reset state
      step(2);
      chk("reset_enable", int'(enable), 0);
      chk("reset_busy",   int'(busy),   0);
      chk("reset_pulses", int'(pulses), 0);
      rst = 1'b0;
      step(1);

      // burst: P=3, N=4
      period = 8'd3; burst_len = 8'd4; start = 1'b1;
      step(1);                       // after edge 0
      start = 1'b0;
      chk("burst_busy_e0", int'(busy), 1);
      step(2);                       // edge 2
      chk("burst_en_e2", int'(enable), 0);
      step(1);                       // edge 3
      chk("burst_en_e3", int'(enable), 1);
      chk("burst_pulses_e3", int'(pulses), 1);
      step(9);                       // edge 12
      chk("burst_en_e12", int'(enable), 1);
      chk("burst_pulses_e12", int'(pulses), 4);
      chk("burst_busy_e12", int'(busy), 1);
      step(1);                       // edge 13
      chk("burst_done_e13", int'(done), 1);
      chk("burst_busy_e13", int'(busy), 0);
      step(1);                       // edge 14
      chk("burst_done_e14", int'(done), 0);
      chk("burst_pulses_hold", int'(pulses), 4);

      // period zero behaves as one
      period = 8'd0; burst_len = 8'd2; start = 1'b1;
      step(1);
      start = 1'b0;
      step(1);
      chk("p0_en_e1", int'(enable), 1);
      step(1);
      chk("p0_en_e2", int'(enable), 1);
      chk("p0_pulses_e2", int'(pulses), 2);
      step(1);
      chk("p0_done_e3", int'(done), 1);
      chk("p0_en_e3", int'(enable), 0);
      step(2);

      // start and stop together: no run
      period = 8'd2; burst_len = 8'd3; start = 1'b1; stop = 1'b1;
      step(1);
      start = 1'b0; stop = 1'b0;
      chk("conflict_busy", int'(busy), 0);
      step(3);
      chk("conflict_still_idle", int'(busy), 0);

      // start re-pulsed and period changed mid-run: ignored
      start = 1'b1;
      step(1);                       // edge 0, P=2 N=3
      start = 1'b0;
      step(1);                       // edge 1
      start = 1'b1; period = 8'd5;
      step(1);                       // edge 2
      start = 1'b0;
      chk("midrun_en_e2", int'(enable), 1);
      step(2);                       // edge 4
      chk("midrun_en_e4", int'(enable), 1);
      chk("midrun_pulses_e4", int'(pulses), 2);
      step(3);                       // edge 7
      chk("midrun_done_e7", int'(done), 1);
      step(2);

      // stop versus strobe: P=4, continuous, stop sampled at edge 8
      period = 8'd4; burst_len = 8'd0; start = 1'b1;
      step(1);
      start = 1'b0;
      step(7);                       // edge 7
      stop = 1'b1;
      step(1);                       // edge 8
      stop = 1'b0;
      chk("stop_en_e8", int'(enable), 0);
      chk("stop_busy_e8", int'(busy), 0);
      chk("stop_pulses_e8", int'(pulses), 1);
      step(1);
      chk("stop_no_done", int'(done), 0);
      step(1);

      // continuous P=1 with wrap
      period = 8'd1; burst_len = 8'd0; start = 1'b1;
      step(1);
      start = 1'b0;
      step(1);
      chk("cont_en_e1", int'(enable), 1);
      chk("cont_pulses_e1", int'(pulses), 1);
      step(254);                     // edge 255
      chk("cont_pulses_e255", int'(pulses), 255);
      step(1);                       // edge 256
      chk("cont_pulses_wrap", int'(pulses), 0);
      chk("cont_en_e256", int'(enable), 1);
      stop = 1'b1;
      step(1);
      stop = 1'b0;
      chk("cont_stop_en", int'(enable), 0);
      chk("cont_stop_busy", int'(busy), 0);
      step(1);
      chk("cont_stop_no_done", int'(done), 0);

      // asynchronous reset mid-burst
      period = 8'd2; burst_len = 8'd5; start = 1'b1;
      step(1);
      start = 1'b0;
      step(4);                       // edge 4: strobe, pulses=2
      chk("rst_pre_pulses", int'(pulses), 2);
      #2 rst = 1'b1;
      #1;
      chk("rst_async_enable", int'(enable), 0);
      chk("rst_async_busy",   int'(busy),   0);
      chk("rst_async_pulses", int'(pulses), 0);
      step(2);
      rst = 1'b0;
      step(1);
      chk("rst_idle_busy", int'(busy), 0);
      period = 8'd3; burst_len = 8'd1; start = 1'b1;
      step(1);
      start = 1'b0;
      chk("rst_restart_pulses", int'(pulses), 0);
      step(3);
      chk("rst_restart_en", int'(enable), 1);
      chk("rst_restart_p1", int'(pulses), 1);
      step(1);
      chk("rst_restart_done", int'(done), 1);
      step(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
